// File: rtl/any1_issue_select.sv
// any1_issue_select: ROB wakeup, oldest-first multi-issue selection with
// branch priority, hold-until-accepted issue slots and a short re-issue
// history that covers the latency of the ROB "out" flag.
module any1_issue_select #(
    parameter int ROB_ENTRIES  = 64,
    parameter int ISSUE_WIDTH  = 2,
    parameter int HIST_DEPTH   = 4,
    parameter int BRANCH_FIRST = 1,
    localparam int IDXW        = $clog2(ROB_ENTRIES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [IDXW-1:0]               head,
    input  logic [ROB_ENTRIES-1:0]        rob_v,
    input  logic [ROB_ENTRIES-1:0]        rob_dec,
    input  logic [ROB_ENTRIES-1:0]        rob_cmt,
    input  logic [ROB_ENTRIES-1:0]        rob_out,
    input  logic [ROB_ENTRIES-1:0]        rob_argrdy,
    input  logic [ROB_ENTRIES-1:0]        rob_mem,
    input  logic [ROB_ENTRIES-1:0]        rob_br,
    input  logic [ROB_ENTRIES-1:0]        rob_fc,
    output logic [ISSUE_WIDTH-1:0]        issue_v,
    output logic [ISSUE_WIDTH*IDXW-1:0]   issue_idx,
    input  logic [ISSUE_WIDTH-1:0]        issue_rdy,
    output logic [ROB_ENTRIES-1:0]        wakeup_list,
    output logic [15:0]                   stall_cnt
);

    // Issue slots, re-issue history and stall counter state
    logic [ISSUE_WIDTH-1:0]                              issue_v_q, issue_v_d;
    logic [ISSUE_WIDTH-1:0][IDXW-1:0]                    issue_idx_q, issue_idx_d;
    logic [HIST_DEPTH-1:0][ISSUE_WIDTH-1:0]              hist_v_q, hist_v_d;
    logic [HIST_DEPTH-1:0][ISSUE_WIDTH-1:0][IDXW-1:0]    hist_idx_q, hist_idx_d;
    logic [15:0]                                         stall_q, stall_d;

    // Combinational working signals; *_age_s vectors are indexed by age
    // (0 = head = oldest), everything else by ROB index.
    logic [ROB_ENTRIES-1:0]            excl_s;
    logic [ROB_ENTRIES-1:0]            elig_age_s;
    logic [ROB_ENTRIES-1:0]            mem_age_s;
    logic [ROB_ENTRIES-1:0]            br_age_s;
    logic [ROB_ENTRIES-1:0]            wakeup_s;
    logic [ISSUE_WIDTH-1:0]            free_s;
    logic [ISSUE_WIDTH-1:0]            sel_v_s;
    logic [ISSUE_WIDTH-1:0][IDXW-1:0]  sel_idx_s;
    logic                              stall_s;

    // Indices currently sitting in a slot or in the history may not be picked again
    always_comb begin
        excl_s = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            excl_s[issue_idx_q[k]] = excl_s[issue_idx_q[k]] | issue_v_q[k];
        end
        for (int h = 0; h < HIST_DEPTH; h++) begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                excl_s[hist_idx_q[h][k]] = excl_s[hist_idx_q[h][k]] | hist_v_q[h][k];
            end
        end
    end

    // Wakeup: walk entries from oldest to youngest, carrying "an older
    // unresolved flow-control op / memory op exists" flags as running ORs
    always_comb begin
        logic            fc_seen;
        logic            mem_seen;
        logic            base;
        logic [IDXW-1:0] n;
        fc_seen    = 1'b0;
        mem_seen   = 1'b0;
        base       = 1'b0;
        n          = '0;
        elig_age_s = '0;
        mem_age_s  = '0;
        br_age_s   = '0;
        wakeup_s   = '0;
        for (int a = 0; a < ROB_ENTRIES; a++) begin
            n    = head + IDXW'(a);
            base = rob_v[n] & rob_dec[n] & ~rob_cmt[n] & ~rob_out[n] & rob_argrdy[n] & ~excl_s[n];
            elig_age_s[a] = base & ~fc_seen & ~(rob_mem[n] & mem_seen);
            mem_age_s[a]  = rob_mem[n];
            br_age_s[a]   = rob_br[n];
            wakeup_s[n]   = elig_age_s[a];
            fc_seen  = fc_seen  | (rob_v[n] & rob_fc[n] & ~rob_cmt[n]);
            mem_seen = mem_seen | (rob_v[n] & rob_mem[n] & ~rob_cmt[n] & ~rob_out[n]);
        end
    end

    // A slot can take a new selection when empty or being accepted this cycle
    always_comb begin
        free_s  = ~issue_v_q | issue_rdy;
        stall_s = (|wakeup_s) & ~(|free_s);
    end

    // Selection: fill free slots in ascending order, oldest first, slot 0
    // optionally reserved for the oldest branch, at most one memory op
    always_comb begin
        logic [ROB_ENTRIES-1:0] taken;
        logic [ROB_ENTRIES-1:0] cand;
        logic                   mem_used;
        logic                   found;
        int                     pick;
        taken     = '0;
        cand      = '0;
        mem_used  = 1'b0;
        found     = 1'b0;
        pick      = 0;
        sel_v_s   = '0;
        sel_idx_s = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            found = 1'b0;
            pick  = 0;
            cand  = elig_age_s & ~taken & ~(mem_age_s & {ROB_ENTRIES{mem_used}});
            if (free_s[k]) begin
                if ((BRANCH_FIRST != 0) && (k == 0)) begin
                    for (int a = 0; a < ROB_ENTRIES; a++) begin
                        if (!found && cand[a] && br_age_s[a]) begin
                            found = 1'b1;
                            pick  = a;
                        end else begin
                            pick  = pick;
                        end
                    end
                end else begin
                    found = 1'b0;
                end
                for (int a = 0; a < ROB_ENTRIES; a++) begin
                    if (!found && cand[a]) begin
                        found = 1'b1;
                        pick  = a;
                    end else begin
                        pick  = pick;
                    end
                end
                if (found) begin
                    sel_v_s[k]   = 1'b1;
                    sel_idx_s[k] = head + IDXW'(pick);
                    taken[pick]  = 1'b1;
                    mem_used     = mem_used | mem_age_s[pick];
                end else begin
                    sel_v_s[k]   = 1'b0;
                end
            end else begin
                sel_v_s[k] = 1'b0;
            end
        end
    end

    // Next state: slot refill/hold, history shift, saturating stall count
    always_comb begin
        issue_v_d   = issue_v_q;
        issue_idx_d = issue_idx_q;
        hist_v_d    = hist_v_q;
        hist_idx_d  = hist_idx_q;
        if (flush) begin
            issue_v_d = '0;
            hist_v_d  = '0;
        end else begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (free_s[k]) begin
                    issue_v_d[k]   = sel_v_s[k];
                    issue_idx_d[k] = sel_v_s[k] ? sel_idx_s[k] : issue_idx_q[k];
                end else begin
                    issue_v_d[k]   = issue_v_q[k];
                end
            end
            for (int h = 1; h < HIST_DEPTH; h++) begin
                hist_v_d[h]   = hist_v_q[h-1];
                hist_idx_d[h] = hist_idx_q[h-1];
            end
            hist_v_d[0]   = issue_v_q & issue_rdy;
            hist_idx_d[0] = issue_idx_q;
        end
        if (stall_s && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_v_q   <= '0;
            issue_idx_q <= '0;
            hist_v_q    <= '0;
            hist_idx_q  <= '0;
            stall_q     <= 16'd0;
        end else begin
            issue_v_q   <= issue_v_d;
            issue_idx_q <= issue_idx_d;
            hist_v_q    <= hist_v_d;
            hist_idx_q  <= hist_idx_d;
            stall_q     <= stall_d;
        end
    end

    assign issue_v     = issue_v_q;
    assign issue_idx   = issue_idx_q;
    assign wakeup_list = wakeup_s;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_any1_issue_select.sv
// tb_any1_issue_select: directed stimulus on two schedulers (branch-first
// on and off) checked each cycle against a behavioural model, plus
// hand-computed literal expectations for the key scenarios.
module tb_any1_issue_select;

    localparam int N = 64;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [5:0]  head;
    logic [63:0] r_v, r_dec, r_cmt, r_out, r_arg, r_mem, r_br, r_fc;
    logic [1:0]  rdy;

    logic [1:0]  dv  [2];
    logic [11:0] dx  [2];
    logic [63:0] dwl [2];
    logic [15:0] dst [2];

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // behavioural model state, per instance
    bit mv    [2][2];
    int midx  [2][2];
    int macc  [2][N];
    int mstall[2];
    int cyc = 0;

    always #5 clk = ~clk;

    any1_issue_select #(.ROB_ENTRIES(64), .ISSUE_WIDTH(2), .HIST_DEPTH(4), .BRANCH_FIRST(1)) u_bf1 (
        .clk(clk), .rst(rst), .flush(flush), .head(head),
        .rob_v(r_v), .rob_dec(r_dec), .rob_cmt(r_cmt), .rob_out(r_out), .rob_argrdy(r_arg),
        .rob_mem(r_mem), .rob_br(r_br), .rob_fc(r_fc),
        .issue_v(dv[0]), .issue_idx(dx[0]), .issue_rdy(rdy),
        .wakeup_list(dwl[0]), .stall_cnt(dst[0]));

    any1_issue_select #(.ROB_ENTRIES(64), .ISSUE_WIDTH(2), .HIST_DEPTH(4), .BRANCH_FIRST(0)) u_bf0 (
        .clk(clk), .rst(rst), .flush(flush), .head(head),
        .rob_v(r_v), .rob_dec(r_dec), .rob_cmt(r_cmt), .rob_out(r_out), .rob_argrdy(r_arg),
        .rob_mem(r_mem), .rob_br(r_br), .rob_fc(r_fc),
        .issue_v(dv[1]), .issue_idx(dx[1]), .issue_rdy(rdy),
        .wakeup_list(dwl[1]), .stall_cnt(dst[1]));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    // One model cycle per instance: derive eligibility from the rules,
    // compare the DUT, then advance the model across the coming edge.
    task automatic model_cycle();
        logic [63:0] el;
        bit          fr [2];
        bit          tk [N];
        bit          sv [2];
        int          sidx [2];
        bit          mused;
        bit          ok;
        bit          stl;
        int          order [$];
        int          pick;
        int          agen;
        int          agem;
        int          nn;
        for (int i = 0; i < 2; i++) begin
            el = '0;
            for (int n = 0; n < N; n++) begin
                agen = (n - int'(head) + N) % N;
                ok = r_v[n] && r_dec[n] && !r_cmt[n] && !r_out[n] && r_arg[n];
                for (int k = 0; k < 2; k++) if (mv[i][k] && midx[i][k] == n) ok = 1'b0;
                if (cyc - macc[i][n] <= H) ok = 1'b0;
                for (int m = 0; m < N; m++) begin
                    agem = (m - int'(head) + N) % N;
                    if (agem < agen) begin
                        if (r_v[m] && r_fc[m] && !r_cmt[m]) ok = 1'b0;
                        if (r_mem[n] && r_v[m] && r_mem[m] && !r_cmt[m] && !r_out[m]) ok = 1'b0;
                    end
                end
                el[n] = ok;
            end
            if (chk_en) begin
                chk($sformatf("model wakeup_list dut%0d cyc%0d", i, cyc), dwl[i], el);
                chk($sformatf("model issue_v dut%0d cyc%0d", i, cyc), 64'(dv[i]), {62'd0, mv[i][1], mv[i][0]});
                chk($sformatf("model stall_cnt dut%0d cyc%0d", i, cyc), 64'(dst[i]), 64'(mstall[i]));
                for (int k = 0; k < 2; k++) begin
                    if (mv[i][k]) chk($sformatf("model issue_idx%0d dut%0d cyc%0d", k, i, cyc),
                                      64'((dx[i] >> (6*k)) & 12'h03F), 64'(midx[i][k]));
                end
            end
            order.delete();
            for (int a = 0; a < N; a++) begin
                nn = (int'(head) + a) % N;
                if (el[nn]) order.push_back(nn);
            end
            for (int n = 0; n < N; n++) tk[n] = 1'b0;
            mused = 1'b0;
            for (int k = 0; k < 2; k++) fr[k] = !mv[i][k] || rdy[k];
            stl = (el != 64'd0) && !fr[0] && !fr[1];
            for (int k = 0; k < 2; k++) begin
                sv[k] = 1'b0;
                sidx[k] = 0;
                if (fr[k]) begin
                    pick = -1;
                    if (i == 0 && k == 0) begin
                        foreach (order[j]) if (pick < 0 && r_br[order[j]] && !tk[order[j]] &&
                                               !(r_mem[order[j]] && mused)) pick = order[j];
                    end
                    foreach (order[j]) if (pick < 0 && !tk[order[j]] && !(r_mem[order[j]] && mused)) pick = order[j];
                    if (pick >= 0) begin
                        sv[k] = 1'b1;
                        sidx[k] = pick;
                        tk[pick] = 1'b1;
                        if (r_mem[pick]) mused = 1'b1;
                    end
                end
            end
            if (rst) begin
                for (int k = 0; k < 2; k++) begin mv[i][k] = 1'b0; midx[i][k] = 0; end
                for (int n = 0; n < N; n++) macc[i][n] = -1000;
                mstall[i] = 0;
            end else begin
                if (stl && mstall[i] < 65535) mstall[i]++;
                if (flush) begin
                    for (int k = 0; k < 2; k++) mv[i][k] = 1'b0;
                    for (int n = 0; n < N; n++) macc[i][n] = -1000;
                end else begin
                    for (int k = 0; k < 2; k++) if (mv[i][k] && rdy[k]) macc[i][midx[i][k]] = cyc;
                    for (int k = 0; k < 2; k++) begin
                        if (fr[k]) begin
                            mv[i][k] = sv[k];
                            if (sv[k]) midx[i][k] = sidx[k];
                        end
                    end
                end
            end
        end
        cyc++;
    endtask

    // Model runs every cycle; comparisons only once reset has been applied
    always @(negedge clk) model_cycle();

    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        r_v = '0; r_dec = '0; r_cmt = '0; r_out = '0; r_arg = '0;
        r_mem = '0; r_br = '0; r_fc = '0;
    endtask

    task automatic ready(input int n);
        r_v[n] = 1'b1; r_dec[n] = 1'b1; r_arg[n] = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; head = 6'd0; rdy = 2'b00;
        clr();
        tick(2);
        chk("reset issue_v", 64'(dv[0]), 64'd0);
        chk("reset issue_idx", 64'(dx[0]), 64'd0);
        chk("reset stall_cnt", 64'(dst[0]), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // basic dual issue and re-issue block
        rdy = 2'b11; ready(3); ready(5);
        tick(1);
        chk("basic slots", {50'd0, dv[0], dx[0]}, {50'd0, 2'b11, 6'd5, 6'd3});
        for (int j = 2; j <= 6; j++) begin
            tick(1);
            chk($sformatf("reissue block t%0d", j), 64'(dv[0]), 64'd0);
        end
        chk("reissue wakeup", dwl[0], 64'h28);
        tick(1);
        chk("reissue after history", {50'd0, dv[0], dx[0]}, {50'd0, 2'b11, 6'd5, 6'd3});
        clr(); tick(6);

        // wrap-around age
        head = 6'd62; ready(1); ready(63);
        tick(1);
        chk("wrap slots", {50'd0, dv[0], dx[0]}, {50'd0, 2'b11, 6'd1, 6'd63});
        clr(); head = 6'd0; tick(6);

        // branch priority on/off
        ready(2); ready(7); r_br[7] = 1'b1;
        tick(1);
        chk("branch first", {50'd0, dv[0], dx[0]}, {50'd0, 2'b11, 6'd2, 6'd7});
        chk("branch off", {50'd0, dv[1], dx[1]}, {50'd0, 2'b11, 6'd7, 6'd2});
        clr(); tick(6);

        // older unissued memory op blocks a younger ready one
        r_v[4] = 1'b1; r_dec[4] = 1'b1; r_mem[4] = 1'b1;
        ready(6); r_mem[6] = 1'b1;
        tick(3);
        chk("mem blocked v", 64'(dv[0]), 64'd0);
        chk("mem blocked wakeup", dwl[0], 64'd0);
        r_out[4] = 1'b1;
        tick(1);
        chk("mem released", {56'd0, dv[0], dx[0][5:0]}, {56'd0, 2'b01, 6'd6});
        clr(); tick(6);

        // uncommitted flow control blocks younger entries
        r_v[1] = 1'b1; r_dec[1] = 1'b1; r_fc[1] = 1'b1;
        ready(2); ready(3);
        tick(3);
        chk("fc blocked", 64'(dv[0]), 64'd0);
        r_cmt[1] = 1'b1;
        tick(1);
        chk("fc released", {50'd0, dv[0], dx[0]}, {50'd0, 2'b11, 6'd3, 6'd2});
        clr(); tick(6);

        // back-pressure and stall counting
        rdy = 2'b00; ready(10); ready(11); ready(12);
        tick(1);
        chk("bp fill", {50'd0, dv[0], dx[0]}, {50'd0, 2'b11, 6'd11, 6'd10});
        tick(10);
        chk("bp hold", {50'd0, dv[0], dx[0]}, {50'd0, 2'b11, 6'd11, 6'd10});
        chk("bp stall_cnt", 64'(dst[0]), 64'd10);
        rdy = 2'b11;
        tick(1);
        chk("bp refill", {56'd0, dv[0], dx[0][5:0]}, {56'd0, 2'b01, 6'd12});
        chk("bp stall_cnt kept", 64'(dst[0]), 64'd10);

        // flush clears slots and history; accepted indices come straight back
        flush = 1'b1;
        tick(1);
        chk("flush issue_v", 64'(dv[0]), 64'd0);
        flush = 1'b0;
        tick(1);
        chk("post flush reissue", {50'd0, dv[0], dx[0]}, {50'd0, 2'b11, 6'd11, 6'd10});
        chk("post flush stall_cnt", 64'(dst[0]), 64'd10);
        clr(); tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
